// File: rtl/dma_stream_sequencer.sv
// rtl/dma_stream_sequencer.sv - Avalon-ST packet framing sequencer with a one-beat stage and FWFT output FIFO; DMA_SEQ_STATS_EN adds counters
module dma_stream_sequencer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_clk,
    input  logic        rst_reset_n,
    input  logic        enable,
    input  logic [31:0] snk_data,
    input  logic        snk_valid,
    output logic        snk_ready,
    input  logic        snk_startofpacket,
    input  logic        snk_endofpacket,
    input  logic [1:0]  snk_empty,
    output logic [31:0] src_data,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic [1:0]  src_empty,
    output logic        busy,
    output logic        err_framing,
    output logic [15:0] pkt_count,
    output logic [31:0] byte_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;
    state_t state_q, state_d;

    logic        stg_valid_q, stg_valid_d;
    logic [31:0] stg_data_q, stg_data_d;
    logic        stg_sop_q, stg_sop_d;
    logic        stg_eop_q, stg_eop_d;
    logic [1:0]  stg_empty_q, stg_empty_d;
    logic        err_q, err_d;

    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic fifo_full, fifo_empty, stg_writable, accept, load, force_eop;
    logic push, pop, push_eop;
    logic [1:0]  push_empty;
    logic [35:0] head;

    assign fifo_full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign stg_writable = !stg_valid_q || !fifo_full;
    assign accept       = snk_valid && snk_ready;

    always_comb begin
        snk_ready = 1'b0;
        if (rst_reset_n) begin
            case (state_q)
                S_IDLE:  snk_ready = enable && stg_writable;
                S_PASS:  snk_ready = stg_writable;
                S_DROP:  snk_ready = 1'b1;
                default: snk_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        force_eop = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (snk_startofpacket) begin
                        load = 1'b1;
                        if (!snk_endofpacket) state_d = S_PASS;
                    end else begin
                        err_d = 1'b1;
                        if (!snk_endofpacket) state_d = S_DROP;
                    end
                end
            end
            S_PASS: begin
                if (accept) begin
                    load = 1'b1;
                    // A new sop closes the open packet by retagging the staged beat
                    if (snk_startofpacket) begin
                        force_eop = 1'b1;
                        err_d     = 1'b1;
                    end
                    if (snk_endofpacket) state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (accept && snk_endofpacket) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push       = stg_valid_q && !fifo_full && (stg_eop_q || load);
    assign push_eop   = stg_eop_q || force_eop;
    assign push_empty = force_eop ? 2'd0 : stg_empty_q;
    assign pop        = src_valid && src_ready;

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_data_d  = stg_data_q;
        stg_sop_d   = stg_sop_q;
        stg_eop_d   = stg_eop_q;
        stg_empty_d = stg_empty_q;
        if (load) begin
            stg_valid_d = 1'b1;
            stg_data_d  = snk_data;
            stg_sop_d   = snk_startofpacket;
            stg_eop_d   = snk_endofpacket;
            stg_empty_d = snk_endofpacket ? snk_empty : 2'd0;
        end else if (push) begin
            stg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!rst_reset_n) begin
            state_q     <= S_IDLE;
            stg_valid_q <= 1'b0;
            stg_data_q  <= '0;
            stg_sop_q   <= 1'b0;
            stg_eop_q   <= 1'b0;
            stg_empty_q <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            stg_valid_q <= stg_valid_d;
            stg_data_q  <= stg_data_d;
            stg_sop_q   <= stg_sop_d;
            stg_eop_q   <= stg_eop_d;
            stg_empty_q <= stg_empty_d;
            err_q       <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; outputs are masked by the occupancy count instead
    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_empty, push_eop, stg_sop_q, stg_data_q};
    end

    assign head              = mem_q[rd_ptr_q];
    assign src_valid         = !fifo_empty;
    assign src_data          = src_valid ? head[31:0] : '0;
    assign src_startofpacket = src_valid && head[32];
    assign src_endofpacket   = src_valid && head[33];
    assign src_empty         = src_valid ? head[35:34] : 2'd0;
    assign busy              = (state_q != S_IDLE) || stg_valid_q || !fifo_empty;
    assign err_framing       = err_q;

`ifdef DMA_SEQ_STATS_EN
    logic [15:0] pkt_q;
    logic [31:0] bytes_q;

    always_ff @(posedge clk_clk) begin
        if (!rst_reset_n) begin
            pkt_q   <= '0;
            bytes_q <= '0;
        end else if (push) begin
            if (push_eop) pkt_q <= pkt_q + 16'd1;
            bytes_q <= bytes_q + 32'd4 - {30'd0, push_empty};
        end
    end

    assign pkt_count  = pkt_q;
    assign byte_count = bytes_q;
`else
    assign pkt_count  = '0;
    assign byte_count = '0;
`endif
endmodule

// File: tb/tb_dma_stream_sequencer.sv
// tb/tb_dma_stream_sequencer.sv - self-checking bench for dma_stream_sequencer
module tb_dma_stream_sequencer;
    localparam int DEPTH = 8;
`ifdef DMA_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, enable = 1'b1;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
    logic [1:0]  snk_empty = '0;
    logic        snk_ready;
    logic [31:0] src_data;
    logic        src_valid, src_sop, src_eop;
    logic        src_ready = 1'b1;
    logic [1:0]  src_empty;
    logic        busy, err_framing;
    logic [15:0] pkt_count;
    logic [31:0] byte_count;

    always #5 clk = ~clk;

    dma_stream_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_clk(clk), .rst_reset_n(rst_n), .enable(enable),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .snk_startofpacket(snk_sop), .snk_endofpacket(snk_eop), .snk_empty(snk_empty),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_startofpacket(src_sop), .src_endofpacket(src_eop), .src_empty(src_empty),
        .busy(busy), .err_framing(err_framing), .pkt_count(pkt_count), .byte_count(byte_count)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } beat_t;

    typedef struct packed {
        logic rst_n, en, v, s, e;
        logic [1:0]  m;
        logic [31:0] d;
        logic x_rdy, x_sv, x_ss, x_se;
        logic [1:0]  x_sm;
        logic [31:0] x_sd;
        logic x_err, x_busy;
    } vec_t;

    int checks = 0, errors = 0;
    beat_t exp_q[$];
    int exp_err = 0, obs_err = 0, rx_cnt = 0;
    int unsigned exp_pkt = 0, exp_bytes = 0;
    bit m_in_pkt = 0, m_drop = 0, rnd_mode = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Reference model: packet framing rules applied to accepted beats, expected src beats in a queue
    always begin
        beat_t nb, b;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_q.delete();
            m_in_pkt = 0; m_drop = 0;
            exp_err = 0; obs_err = 0; rx_cnt = 0; exp_pkt = 0; exp_bytes = 0;
        end else begin
            if (err_framing) obs_err++;
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL src_unexpected: got beat %0h expected none", src_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("src_beat", {src_sop, src_eop, src_empty, src_data}, {b.s, b.e, b.m, b.d});
                    rx_cnt++;
                    if (b.e) exp_pkt++;
                    exp_bytes += b.e ? 32'(4 - int'(b.m)) : 32'd4;
                end
            end
            if (snk_valid && snk_ready) begin
                nb = {snk_data, snk_sop, snk_eop, snk_eop ? snk_empty : 2'd0};
                if (m_in_pkt) begin
                    if (snk_sop && exp_q.size() > 0) begin
                        exp_q[exp_q.size()-1].e = 1'b1;
                        exp_q[exp_q.size()-1].m = 2'd0;
                        exp_err++;
                    end
                    exp_q.push_back(nb);
                    if (snk_eop) m_in_pkt = 0;
                end else if (m_drop) begin
                    if (snk_eop) m_drop = 0;
                end else if (snk_sop) begin
                    chk("admit_enable", enable, 1'b1);
                    exp_q.push_back(nb);
                    m_in_pkt = !snk_eop;
                end else begin
                    exp_err++;
                    m_drop = !snk_eop;
                end
            end
        end
    end

    always @(negedge clk) if (rnd_mode) src_ready = 1'($urandom_range(0, 1));

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m,
                        input int budget, input bit force_en);
        bit ok = 0;
        @(negedge clk);
        snk_data = d; snk_sop = s; snk_eop = e; snk_empty = m; snk_valid = 1'b1;
        for (int n = 0; n < budget; n++) begin
            if (n > 0) @(negedge clk);
            if (force_en && n >= 3) enable = 1'b1;
            #1;
            if (snk_ready) begin ok = 1; break; end
        end
        if (ok) begin @(posedge clk); #1; end
        snk_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; snk_valid = 1'b0; enable = 1'b1; rnd_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain_check(input string nm);
        bit ok = 0;
        rnd_mode = 0;
        src_ready = 1'b1;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy) ok = 1;
        end
        chk({nm, "_drain"}, ok, 1);
        chk({nm, "_err"}, obs_err, exp_err);
        chk({nm, "_pkt"}, pkt_count, STATS ? exp_pkt[15:0] : 16'd0);
        chk({nm, "_bytes"}, byte_count, STATS ? exp_bytes : 32'd0);
    endtask

    function automatic vec_t mk(logic r, logic en, logic v, logic s, logic e, logic [1:0] m, logic [31:0] d,
                                logic xr, logic xsv, logic xss, logic xse, logic [1:0] xsm,
                                logic [31:0] xsd, logic xerr, logic xbusy);
        return {r, en, v, s, e, m, d, xr, xsv, xss, xse, xsm, xsd, xerr, xbusy};
    endfunction

    vec_t tbl[18];

    initial begin
        bit blocked;
        int cnt;
        tbl[0]  = mk(0,1,0,0,0,0,0,             0,0,0,0,0,0,            0,0);
        tbl[1]  = mk(1,1,1,1,0,0,32'hA0000001,  1,0,0,0,0,0,            0,0);
        tbl[2]  = mk(1,1,1,0,0,3,32'hA0000002,  1,0,0,0,0,0,            0,1);
        tbl[3]  = mk(1,1,1,0,1,2,32'hA0000003,  1,1,1,0,0,32'hA0000001, 0,1);
        tbl[4]  = mk(1,1,0,0,0,0,0,             1,1,0,0,0,32'hA0000002, 0,1);
        tbl[5]  = mk(1,1,0,0,0,0,0,             1,1,0,1,2,32'hA0000003, 0,1);
        tbl[6]  = mk(1,1,0,0,0,0,0,             1,0,0,0,0,0,            0,0);
        tbl[7]  = mk(1,1,1,0,0,0,32'hB0000001,  1,0,0,0,0,0,            0,0);
        tbl[8]  = mk(1,1,1,0,1,0,32'hB0000002,  1,0,0,0,0,0,            1,1);
        tbl[9]  = mk(1,1,0,0,0,0,0,             1,0,0,0,0,0,            0,0);
        tbl[10] = mk(1,1,1,0,1,1,32'hC0000001,  1,0,0,0,0,0,            0,0);
        tbl[11] = mk(1,1,0,0,0,0,0,             1,0,0,0,0,0,            1,0);
        tbl[12] = mk(1,0,1,1,0,0,32'hD0000000,  0,0,0,0,0,0,            0,0);
        tbl[13] = mk(1,0,0,0,0,0,0,             0,0,0,0,0,0,            0,0);
        tbl[14] = mk(1,1,1,1,1,1,32'hD0000001,  1,0,0,0,0,0,            0,0);
        tbl[15] = mk(1,1,0,0,0,0,0,             1,0,0,0,0,0,            0,1);
        tbl[16] = mk(1,1,0,0,0,0,0,             1,1,1,1,1,32'hD0000001, 0,1);
        tbl[17] = mk(1,1,0,0,0,0,0,             1,0,0,0,0,0,            0,0);

        repeat (3) @(negedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; enable = tbl[i].en; snk_valid = tbl[i].v;
            snk_sop = tbl[i].s; snk_eop = tbl[i].e; snk_empty = tbl[i].m; snk_data = tbl[i].d;
            src_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d", i),
                {snk_ready, src_valid, src_sop, src_eop, src_empty, src_data, err_framing, busy},
                {tbl[i].x_rdy, tbl[i].x_sv, tbl[i].x_ss, tbl[i].x_se, tbl[i].x_sm, tbl[i].x_sd,
                 tbl[i].x_err, tbl[i].x_busy});
        end
        chk("vec_pkt", pkt_count, STATS ? 16'd2 : 16'd0);
        chk("vec_bytes", byte_count, STATS ? 32'd13 : 32'd0);
        chk("vec_errs", obs_err, 2);

        // Fill with a stalled consumer: stage plus FIFO absorb DEPTH+1 beats
        do_reset();
        src_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            send(32'h1000 + i, i == 0, 1'b0, 2'd0, 3, 0);
            cnt++;
        end
        chk("fill_accepts", cnt, DEPTH + 1);
        @(negedge clk);
        snk_data = 32'h1000 + DEPTH + 1; snk_sop = 0; snk_eop = 0; snk_valid = 1'b1;
        blocked = 1;
        repeat (3) begin #1; if (snk_ready) blocked = 0; @(negedge clk); end
        chk("fill_block", blocked, 1);
        src_ready = 1'b1;
        send(32'h1000 + DEPTH + 1, 0, 0, 2'd0, 10, 0);
        send(32'h1000 + DEPTH + 2, 0, 1, 2'd3, 10, 0);
        drain_check("fill");
        chk("fill_rx", rx_cnt, DEPTH + 3);

        // sop arriving mid-packet closes the first packet early
        do_reset();
        send(32'hE1, 1, 0, 2'd0, 5, 0);
        send(32'hE2, 0, 0, 2'd3, 5, 0);
        send(32'hF1, 1, 0, 2'd0, 5, 0);
        send(32'hF2, 0, 0, 2'd0, 5, 0);
        send(32'hF3, 0, 1, 2'd1, 5, 0);
        drain_check("midsop");
        chk("midsop_err1", obs_err, 1);
        chk("midsop_pkt2", pkt_count, STATS ? 16'd2 : 16'd0);
        chk("midsop_rx", rx_cnt, 5);

        // enable dropped after sop: packet completes, next sop waits
        do_reset();
        send(32'h61, 1, 0, 2'd0, 5, 0);
        enable = 1'b0;
        send(32'h62, 0, 0, 2'd0, 5, 0);
        send(32'h63, 0, 1, 2'd2, 5, 0);
        @(negedge clk);
        snk_data = 32'h71; snk_sop = 1; snk_eop = 0; snk_valid = 1'b1;
        blocked = 1;
        repeat (5) begin #1; if (snk_ready) blocked = 0; @(negedge clk); end
        chk("enable_block", blocked, 1);
        enable = 1'b1;
        #1;
        chk("enable_resume", snk_ready, 1);
        @(posedge clk); #1; snk_valid = 1'b0;
        send(32'h72, 0, 1, 2'd0, 5, 0);
        drain_check("enable");
        chk("enable_rx", rx_cnt, 5);

        // Reset mid-packet with the FIFO half full
        do_reset();
        src_ready = 1'b0;
        for (int i = 0; i < DEPTH / 2 + 1; i++) send(32'h3000 + i, i == 0, 1'b0, 2'd0, 3, 0);
        chk("half_valid", src_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready_low", snk_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_state", {src_valid, busy, err_framing, pkt_count, byte_count}, '0);
        chk("rst_idle_ready", snk_ready, 1);
        send(32'h3100, 0, 1, 2'd0, 5, 0);
        drain_check("rst");
        chk("rst_err1", obs_err, 1);
        chk("rst_rx", rx_cnt, 0);

        // Randomized framing, enable and backpressure against the model
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            send($urandom, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                 2'($urandom_range(0, 3)), 300, 1);
        end
        enable = 1'b1;
        send(32'hFFFF0000, 0, 1, 2'd0, 300, 1);
        drain_check("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
